// File: rtl/sr_pulse_driver.sv
// Drives the set/reset inputs of an SR status latch with timed, mutually exclusive
// pulses, a dead-time gap, and a q/qn feedback check after every operation.
module sr_pulse_driver #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  output logic req_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  input  logic qn_fb,
  output logic busy,
  output logic done,
  output logic err,
  output logic state_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_W > 0) ? (GAP_W - 1) : 0);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             op_set_reg, op_set_next;
  logic             s_reg, s_next;
  logic             r_reg, r_next;
  logic             busy_reg, busy_next;
  logic             ready_reg;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             state_q_reg, state_q_next;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    op_set_next  = op_set_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    state_q_next = state_q_reg;

    case (state_reg)
      IDLE: begin
        if (set_req || clr_req) begin
          // Clear has priority when both requests arrive together.
          op_set_next = set_req & ~clr_req;
          cnt_next    = PULSE_LOAD;
          state_next  = PULSE;
        end
      end
      PULSE: begin
        if (cnt_reg == '0) begin
          if (GAP_W == 0) begin
            state_next = CHECK;
          end else begin
            state_next = GAP;
            cnt_next   = GAP_LOAD;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg == '0) begin
          state_next = CHECK;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      CHECK: begin
        state_next = IDLE;
        done_next  = 1'b1;
        // An unknown or q==qn feedback falls through to the error branch.
        if ({q_fb, qn_fb} == {op_set_reg, ~op_set_reg}) begin
          state_q_next = op_set_reg;
        end else begin
          err_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Drives are decoded from the next state so s and r can never overlap.
  always_comb begin
    s_next    = (state_next == PULSE) &  op_set_next;
    r_next    = (state_next == PULSE) & ~op_set_next;
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      op_set_reg  <= 1'b0;
      s_reg       <= 1'b0;
      r_reg       <= 1'b0;
      busy_reg    <= 1'b0;
      ready_reg   <= 1'b1;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      state_q_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      op_set_reg  <= op_set_next;
      s_reg       <= s_next;
      r_reg       <= r_next;
      busy_reg    <= busy_next;
      ready_reg   <= ~busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      state_q_reg <= state_q_next;
    end
  end

  assign s         = s_reg;
  assign r         = r_reg;
  assign busy      = busy_reg;
  assign req_ready = ready_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign state_q   = state_q_reg;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Scoreboard bench for sr_pulse_driver with a behavioural SR latch closing the feedback loop.
module tb_sr_pulse_driver;

  localparam int PULSE_W = 2;
  localparam int GAP_W   = 1;
  localparam int CNT_W   = 4;
  localparam int EXP_LAT = PULSE_W + GAP_W + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic req_ready, s, r, q_fb, qn_fb, busy, done, err, state_q;

  sr_pulse_driver #(.PULSE_W(PULSE_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
    .req_ready(req_ready), .s(s), .r(r), .q_fb(q_fb), .qn_fb(qn_fb),
    .busy(busy), .done(done), .err(err), .state_q(state_q)
  );

  always #5 clk = ~clk;

  // Behavioural latch; fault pins q low to emulate a stuck feedback line.
  logic lat_q = 1'b0;
  logic fault = 1'b0;
  always @(s or r) begin
    if (s && !r) lat_q = 1'b1;
    else if (r && !s) lat_q = 1'b0;
  end
  assign q_fb  = fault ? 1'b0 : lat_q;
  assign qn_fb = ~lat_q;

  typedef struct {
    int   s_cnt;
    int   r_cnt;
    logic err;
    logic sq;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Acceptance tracker: records cycle and pulse tallies at each accepted request.
  int cyc = 0, acc_cyc = 0, s_total = 0, r_total = 0, s_base = 0, r_base = 0;
  always @(posedge clk) begin
    if (rst_n && req_ready && (set_req || clr_req)) begin
      acc_cyc = cyc;
      s_base  = s_total;
      r_base  = r_total;
    end
    cyc++;
  end

  // Monitor: overlap check every cycle, scoreboard compare on every done.
  always @(negedge clk) begin
    exp_t e;
    check("s_and_r_exclusive", int'(s & r), 0);
    if (s) s_total++;
    if (r) r_total++;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, expected no pending operation");
      end else begin
        e = sb.pop_front();
        check("err", int'(err), int'(e.err));
        check("state_q", int'(state_q), int'(e.sq));
        check("s_pulse_cycles", s_total - s_base, e.s_cnt);
        check("r_pulse_cycles", r_total - r_base, e.r_cnt);
        check("done_latency", cyc - acc_cyc, EXP_LAT);
        check("ready_with_done", int'(req_ready), 1);
      end
    end
  end

  task automatic issue(input logic sv, input logic cv, input int es, input int er,
                       input logic ee, input logic esq);
    @(negedge clk);
    set_req = sv;
    clr_req = cv;
    sb.push_back('{es, er, ee, esq});
    @(negedge clk);
    set_req = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d pending ops after %0d cycles, expected 0", name, sb.size(), n);
      sb.delete();
    end
  endtask

  initial begin
    int dn;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_s", int'(s), 0);
    check("rst_r", int'(r), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_state_q", int'(state_q), 0);

    issue(1'b1, 1'b0, 2, 0, 1'b0, 1'b1);
    wait_done("set");
    issue(1'b0, 1'b1, 0, 2, 1'b0, 1'b0);
    wait_done("clear");
    issue(1'b1, 1'b1, 0, 2, 1'b0, 1'b0);
    wait_done("both");

    // Feedback fault, with set_req held while busy: exactly one operation expected.
    fault = 1'b1;
    @(negedge clk);
    set_req = 1'b1;
    sb.push_back('{2, 0, 1'b1, 1'b0});
    repeat (3) begin
      @(negedge clk);
      check("busy_while_held", int'(busy), 1);
      check("not_ready_while_held", int'(req_ready), 0);
    end
    set_req = 1'b0;
    wait_done("fault");
    fault = 1'b0;

    // Request held across done: second op accepted on the edge done is seen.
    @(negedge clk);
    set_req = 1'b1;
    sb.push_back('{2, 0, 1'b0, 1'b1});
    sb.push_back('{2, 0, 1'b0, 1'b1});
    repeat (6) @(posedge clk);
    @(negedge clk);
    set_req = 1'b0;
    wait_done("back_to_back");

    // Asynchronous reset while s is high in cycle 1.
    @(negedge clk);
    set_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_req = 1'b0;
    check("s_cycle1_before_reset", int'(s), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_s", int'(s), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ready", int'(req_ready), 1);
    check("async_rst_state_q", int'(state_q), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (done) dn++;
    end
    check("no_done_after_reset", dn, 0);
    check("idle_after_reset", int'(busy), 0);

    issue(1'b0, 1'b1, 0, 2, 1'b0, 1'b0);
    wait_done("clear_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
